sram_req_arbiter: RTL
=====================

// Module: sram_req_arbiter
// PURPOSE
//  Front end of the sram2axi bridge. Accepts the CPU's inst and data sram-like requests and arbitrates them one per cycle.
//  Dispatches each granted request to the AR/R read channel (rd_*) or the AW/W/B write channel (wr_*).
//  Returns addr_ok, data_ok and rdata to the issuing master, in request order per master.
// PARAMETERS
//  MAX_OUT   2   max outstanding transactions per master (1..7)
//  CNT_W     3   outstanding-counter width; must hold MAX_OUT
// PORTS
//  clk                   in   1   clock, all logic on posedge
//  resetn                in   1   asynchronous, active-low reset
//  inst_sram_req/wr      in   1   inst request / write flag (inst writes are illegal and are ignored)
//  inst_sram_size        in   2   0=byte 1=half 2=word
//  inst_sram_addr        in   32  inst address
//  inst_sram_addr_ok     out  1   inst request accepted this cycle
//  inst_sram_data_ok     out  1   inst read data valid
//  inst_sram_rdata       out  32  inst read data
//  data_sram_req/wr      in   1   data request / write flag
//  data_sram_size        in   2   size, as inst
//  data_sram_wstrb       in   4   byte strobes (write only)
//  data_sram_addr/wdata  in   32  data address / write data
//  data_sram_addr_ok     out  1   data request accepted
//  data_sram_data_ok     out  1   data read data valid or write complete
//  data_sram_rdata       out  32  data read data
//  rd_req/rd_ready       out/in 1 read-issue handshake to the read channel
//  rd_id                 out  4   0=inst 1=data
//  rd_addr/rd_size       out  32/3  address / size ({1'b0,size})
//  rd_resp_valid         in   1   one-cycle pulse from the read channel
//  rd_resp_id            in   4   id of the returning read
//  rd_resp_data          in   32  returning read data
//  wr_req/wr_ready       out/in 1 write-issue handshake to the write channel
//  wr_addr/wr_size/wr_wstrb/wr_wdata  out  32/3/4/32  write payload
//  wr_resp_valid         in   1   one-cycle pulse on B response
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0; RR pointer = data.
//  - Eligibility:
//    - Master eligible if req=1 and its out_cnt<MAX_OUT.
//    - Data additionally needs no outstanding ops of the opposite type: op_type reg, changeable only at cnt==0.
//    - inst_sram_wr=1 is never granted.
//  - FSM IDLE -> RD_ISSUE / WR_ISSUE:
//    - In IDLE, grant one eligible master; addr_ok=1 combinationally in that same cycle.
//    - Capture the request into the issue registers; rd_req or wr_req rises the next cycle.
//  - RD_ISSUE / WR_ISSUE:
//    - Hold rd_*/wr_* stable until rd_ready/wr_ready=1 is sampled, then return to IDLE.
//    - No new grant while not IDLE: 2-cycle minimum issue interval.
//  - Counters:
//    - out_cnt[m] +1 on grant, -1 on the matching response (rd_resp_id, or wr_resp_valid for data).
//    - Same cycle: unchanged.
//    - Response at cnt==0 is a protocol error: ignored, cnt stays 0.
//  - Response path:
//    - data_ok and rdata are registered one cycle after rd_resp_valid/wr_resp_valid.
//    - data_ok is a 1-cycle pulse; rdata holds until the next data_ok of that master; write data_ok has rdata=0.
//    - Same cycle rd_resp (inst) and wr_resp: both delivered in the same cycle.
//  - resetn low mid-transaction: everything clears asynchronously; in-flight responses after release are dropped.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN:
//    - defined: inst and data alternate when both are eligible; the pointer flips to the other master after each grant.
//    - undefined: fixed priority, data over inst.
// STRUCTURE
//  - Shared sram_bridge_defs.vh:
//    - ID_INST=4'd0, ID_DATA=4'd1
//    - FSM encodings IDLE=2'd0, RD_ISSUE=2'd1, WR_ISSUE=2'd2
//    - SIZE_* constants
//  - One sub-module, sram_rr_arb (2-requester grant logic + pointer); all else inline.
// TESTING
//  - Inst read 0xBFC00000: addr_ok in cycle 0, rd_req at cycle 1 with rd_id=0; rd_ready at cycle 3, rd_resp_valid at 5 with data 0x3C1D0001 -> inst_data_ok at 6, rdata 0x3C1D0001.
//  - Inst and data reads requested in the same cycle, fixed priority: data granted first (rd_id=1); inst granted the first IDLE cycle after.
//    - With ARB_ROUND_ROBIN_EN: grants alternate D,I,D,I over 4 back-to-back pairs.
//  - Data write 0x80001000, wstrb=4'b0011, wdata=0x0000BEEF: wr_* carries those values; wr_resp_valid -> data_data_ok one cycle later, rdata=0.
//  - MAX_OUT=2, inst req held with no responses: exactly 2 addr_ok, third held off; one rd_resp_valid(id 0) -> third accepted the next IDLE cycle.
//  - Data read outstanding plus a data write request: write not granted until the read's data_ok; then granted.
//  - Assert resetn=0 while in RD_ISSUE: rd_req=0, counters=0, state IDLE immediately; then a stray rd_resp_valid -> no data_ok.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared IDs, FSM encoding, size codes and helpers for the sram request arbiter.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN.
package sram_req_arbiter_pkg;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    WR_ISSUE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Arbitration pointer: which master wins when both are eligible.
  localparam logic PTR_INST = 1'b0;
  localparam logic PTR_DATA = 1'b1;

  // sram-like size codes map onto the AXI size field with a zero MSB.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester grant logic (inst vs data) with a priority pointer.
// ARB_ROUND_ROBIN_EN defined: pointer flips after each grant; undefined: data always wins.
module sram_rr_arb
  import sram_req_arbiter_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic req_inst,
  input  logic req_data,
  output logic grant_inst,
  output logic grant_data
);

  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    grant_data = en & req_data & ((ptr_reg == PTR_DATA) | ~req_inst);
    grant_inst = en & req_inst & ((ptr_reg == PTR_INST) | ~req_data);
`ifdef ARB_ROUND_ROBIN_EN
    ptr_next = ptr_reg;
    if (grant_data) begin
      ptr_next = PTR_INST;
    end else if (grant_inst) begin
      ptr_next = PTR_DATA;
    end
`else
    // Fixed priority is the pointer pinned at data.
    ptr_next = PTR_DATA;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= PTR_DATA;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Front end of the sram2axi bridge: arbitrates inst/data sram-like requests onto
// the read/write issue channels and returns data_ok/rdata per master. Macro: ARB_ROUND_ROBIN_EN.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        rd_req,
  input  logic        rd_ready,
  output logic [3:0]  rd_id,
  output logic [31:0] rd_addr,
  output logic [2:0]  rd_size,
  input  logic        rd_resp_valid,
  input  logic [3:0]  rd_resp_id,
  input  logic [31:0] rd_resp_data,
  output logic        wr_req,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [2:0]  wr_size,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_wdata,
  input  logic        wr_resp_valid
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e state_reg, state_next;

  logic [CNT_W-1:0] inst_cnt_reg, inst_cnt_next;
  logic [CNT_W-1:0] data_cnt_reg, data_cnt_next;
  logic             data_op_wr_reg;

  logic [3:0]  iss_id_reg;
  logic [31:0] iss_addr_reg;
  logic [2:0]  iss_size_reg;
  logic [3:0]  iss_wstrb_reg;
  logic [31:0] iss_wdata_reg;

  logic        inst_data_ok_reg;
  logic [31:0] inst_rdata_reg;
  logic        data_data_ok_reg;
  logic [31:0] data_rdata_reg;

  logic inst_elig, data_elig;
  logic grant_inst, grant_data;
  logic inst_resp_hit, data_rd_hit, data_wr_hit, data_resp_hit;

  // Data may only mix reads and writes once everything in flight has drained.
  assign inst_elig = inst_sram_req & ~inst_sram_wr & (inst_cnt_reg < MAX_CNT);
  assign data_elig = data_sram_req & (data_cnt_reg < MAX_CNT) &
                     ((data_cnt_reg == '0) | (data_op_wr_reg == data_sram_wr));

  sram_rr_arb u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .en         (state_reg == IDLE),
    .req_inst   (inst_elig),
    .req_data   (data_elig),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  assign inst_sram_addr_ok = grant_inst;
  assign data_sram_addr_ok = grant_data;

  // Responses with nothing outstanding (e.g. in flight across a reset) are dropped.
  assign inst_resp_hit = rd_resp_valid & (rd_resp_id == ID_INST) & (inst_cnt_reg != '0);
  assign data_rd_hit   = rd_resp_valid & (rd_resp_id == ID_DATA) & (data_cnt_reg != '0) & ~data_op_wr_reg;
  assign data_wr_hit   = wr_resp_valid & (data_cnt_reg != '0) & data_op_wr_reg;
  assign data_resp_hit = data_rd_hit | data_wr_hit;

  always_comb begin
    inst_cnt_next = inst_cnt_reg;
    case ({grant_inst, inst_resp_hit})
      2'b10:   inst_cnt_next = inst_cnt_reg + CNT_ONE;
      2'b01:   inst_cnt_next = inst_cnt_reg - CNT_ONE;
      default: inst_cnt_next = inst_cnt_reg;
    endcase
    data_cnt_next = data_cnt_reg;
    case ({grant_data, data_resp_hit})
      2'b10:   data_cnt_next = data_cnt_reg + CNT_ONE;
      2'b01:   data_cnt_next = data_cnt_reg - CNT_ONE;
      default: data_cnt_next = data_cnt_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_inst) begin
          state_next = RD_ISSUE;
        end else if (grant_data) begin
          state_next = data_sram_wr ? WR_ISSUE : RD_ISSUE;
        end
      end
      RD_ISSUE: if (rd_ready) state_next = IDLE;
      WR_ISSUE: if (wr_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      inst_cnt_reg   <= '0;
      data_cnt_reg   <= '0;
      data_op_wr_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inst_cnt_reg <= inst_cnt_next;
      data_cnt_reg <= data_cnt_next;
      if (grant_data) begin
        data_op_wr_reg <= data_sram_wr;
      end
    end
  end

  // Issue registers are shared by both channels; only the active one requests.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iss_id_reg    <= '0;
      iss_addr_reg  <= '0;
      iss_size_reg  <= '0;
      iss_wstrb_reg <= '0;
      iss_wdata_reg <= '0;
    end else if (grant_inst) begin
      iss_id_reg    <= ID_INST;
      iss_addr_reg  <= inst_sram_addr;
      iss_size_reg  <= axi_size(inst_sram_size);
      iss_wstrb_reg <= '0;
      iss_wdata_reg <= '0;
    end else if (grant_data) begin
      iss_id_reg    <= ID_DATA;
      iss_addr_reg  <= data_sram_addr;
      iss_size_reg  <= axi_size(data_sram_size);
      iss_wstrb_reg <= data_sram_wr ? data_sram_wstrb : 4'b0000;
      iss_wdata_reg <= data_sram_wr ? data_sram_wdata : 32'h0;
    end
  end

  assign rd_req   = (state_reg == RD_ISSUE);
  assign rd_id    = iss_id_reg;
  assign rd_addr  = iss_addr_reg;
  assign rd_size  = iss_size_reg;
  assign wr_req   = (state_reg == WR_ISSUE);
  assign wr_addr  = iss_addr_reg;
  assign wr_size  = iss_size_reg;
  assign wr_wstrb = iss_wstrb_reg;
  assign wr_wdata = iss_wdata_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_data_ok_reg <= 1'b0;
      inst_rdata_reg   <= '0;
      data_data_ok_reg <= 1'b0;
      data_rdata_reg   <= '0;
    end else begin
      inst_data_ok_reg <= inst_resp_hit;
      data_data_ok_reg <= data_resp_hit;
      if (inst_resp_hit) begin
        inst_rdata_reg <= rd_resp_data;
      end
      // A write completion reports zero read data.
      if (data_rd_hit) begin
        data_rdata_reg <= rd_resp_data;
      end else if (data_wr_hit) begin
        data_rdata_reg <= 32'h0;
      end
    end
  end

  assign inst_sram_data_ok = inst_data_ok_reg;
  assign inst_sram_rdata   = inst_rdata_reg;
  assign data_sram_data_ok = data_data_ok_reg;
  assign data_sram_rdata   = data_rdata_reg;

endmodule
